// File: rtl/audio_tdm_serializer.sv
// audio_tdm_serializer: I2S (MODE 0) / TDM (MODE 1) serializer with a staging and a shift buffer.
// Define AUD_UNDERRUN_DET_EN to add o_underrun and zero-fill frames that had no i_load.
module audio_tdm_serializer #(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int BCK_DIV  = 4,
    parameter int MODE     = 0
) (
    input  logic                         AUDIO_CLK,
    input  logic                         reset_reg_N,
    input  logic [CHANNELS*SAMPLE_W-1:0] i_samples,
    input  logic                         i_load,
    output logic                         o_frame_req,
    output logic                         oAUD_BCK,
    output logic                         oAUD_LRCK,
`ifdef AUD_UNDERRUN_DET_EN
    output logic                         oAUD_DATA,
    output logic                         o_underrun
`else
    output logic                         oAUD_DATA
`endif
);
    localparam int FRAME = CHANNELS * SLOT_W;
    localparam int BUF_W = CHANNELS * SAMPLE_W;
    localparam int DIV_W = $clog2(BCK_DIV);
    localparam int BIT_W = $clog2(FRAME);
    localparam int IDX_W = $clog2(BUF_W);

    logic [DIV_W-1:0] div, div_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt, lag_pos;
    logic [BUF_W-1:0] stage, shift_buf, shift_nxt;
    logic             fall, wrap, starve, data_nxt, lrck_nxt;

    // Bit k of slot s in the frame bit stream, MSB first with zero padding.
    function automatic logic stream_bit(input logic [BUF_W-1:0] smp, input logic [BIT_W-1:0] pos);
        int slot, k;
        slot = int'(pos) / SLOT_W;
        k = int'(pos) % SLOT_W;
        stream_bit = 1'b0;
        if (k < SAMPLE_W) stream_bit = smp[IDX_W'(slot * SAMPLE_W + SAMPLE_W - 1 - k)];
    endfunction

`ifdef AUD_UNDERRUN_DET_EN
    logic loaded;
    assign starve = !loaded;
`else
    assign starve = 1'b0;
`endif

    always_comb begin
        fall      = div == DIV_W'(BCK_DIV - 1);
        div_nxt   = fall ? '0 : div + DIV_W'(1);
        wrap      = fall && bit_cnt == BIT_W'(FRAME - 1);
        bit_nxt   = fall ? (wrap ? '0 : bit_cnt + BIT_W'(1)) : bit_cnt;
        shift_nxt = wrap ? (starve ? '0 : stage) : shift_buf;
        // I2S delays data one BCK, so position 0 still shows the old buffer's last bit.
        lag_pos   = (bit_nxt == '0) ? BIT_W'(FRAME - 1) : bit_nxt - BIT_W'(1);
        data_nxt  = (MODE == 0) ? stream_bit(shift_buf, lag_pos) : stream_bit(shift_nxt, bit_nxt);
        lrck_nxt  = (MODE == 0) ? (bit_nxt >= BIT_W'(SLOT_W)) : (bit_nxt == '0);
    end

    always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            div         <= '0;
            bit_cnt     <= '0;
            stage       <= '0;
            shift_buf   <= '0;
            o_frame_req <= 1'b0;
            oAUD_BCK    <= 1'b0;
            oAUD_LRCK   <= 1'b0;
            oAUD_DATA   <= 1'b0;
`ifdef AUD_UNDERRUN_DET_EN
            loaded      <= 1'b0;
            o_underrun  <= 1'b0;
`endif
        end else begin
            div         <= div_nxt;
            oAUD_BCK    <= div_nxt >= DIV_W'(BCK_DIV / 2);
            o_frame_req <= wrap;
            shift_buf   <= shift_nxt;
            if (i_load) stage <= i_samples;
            if (fall) begin
                bit_cnt   <= bit_nxt;
                oAUD_DATA <= data_nxt;
                oAUD_LRCK <= lrck_nxt;
            end
`ifdef AUD_UNDERRUN_DET_EN
            if (wrap) begin
                o_underrun <= starve;
                loaded     <= i_load;
            end else if (i_load) begin
                loaded <= 1'b1;
            end
`endif
        end
    end
endmodule
